// File: rtl/tmp_pkg.sv
// Shared types and default constants for the temperature-sensor result decoder.
// Combinational only; no latency or backpressure of its own.
package tmp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2
    } state_t;

    localparam int DEF_WIN_LOG2    = 6;
    localparam int DEF_SETTLE_EVTS = 5;
    localparam int DEF_TIMEOUT     = 255;

endpackage

// File: rtl/tmp_evt_watchdog.sv
// Stall watchdog: counts event-free cycles while active, fires after TIMEOUT of them.
// Fire is combinational from the counter; the counter rearms on the cycle it fires.
// No backpressure; clr (event or restart) always wins over firing.
module tmp_evt_watchdog
    import tmp_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic clr,
    output logic fire
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] idle_cnt;

    assign fire = active && !clr && (idle_cnt == LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (!active || clr || fire) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tmp_result_decoder.sv
// Turns src/snk charge events into a src-density temperature code over a 64-event window.
// Result valid one cycle after the final window event; held until res_valid && res_ready.
// No stall on the producer side: an unread result is overwritten and overrun is flagged.
module tmp_result_decoder
    import tmp_pkg::*;
#(
    parameter int WIN_LOG2    = DEF_WIN_LOG2,
    parameter int SETTLE_EVTS = DEF_SETTLE_EVTS,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                conv_start,
    input  logic                src_evt,
    input  logic                snk_evt,
    output logic [WIN_LOG2:0]   res_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                busy,
    output logic                overrun,
    output logic                proto_err,
    output logic                timeout_err
);

    localparam int CW  = WIN_LOG2 + 1;
    localparam int WIN = 1 << WIN_LOG2;
    localparam int SW  = $clog2(SETTLE_EVTS + 1);

    state_t          state, state_nxt;
    logic [SW-1:0]   settle_cnt;
    logic [CW-1:0]   tot_cnt;
    logic [CW-1:0]   src_cnt;

    logic both_evt, ev, active, restart, wd_fire;
    logic settle_last, win_last, done, hs;

    // Simultaneous src/snk is a protocol violation and never counts as an event.
    assign both_evt    = src_evt && snk_evt;
    assign ev          = enable && (src_evt ^ snk_evt);
    assign active      = (state != IDLE);
    assign restart     = enable && active && conv_start;
    assign settle_last = (state == SETTLE) && ev && (settle_cnt == SW'(SETTLE_EVTS - 1));
    assign win_last    = (state == ACCUM) && ev && (tot_cnt == CW'(WIN - 1));
    assign done        = win_last && !restart;
    assign hs          = res_valid && res_ready;

    tmp_evt_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .active (active && enable),
        .clr    (ev || restart),
        .fire   (wd_fire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (conv_start) state_nxt = SETTLE;
                end
                SETTLE: begin
                    if (restart)          state_nxt = SETTLE;
                    else if (wd_fire)     state_nxt = IDLE;
                    else if (settle_last) state_nxt = ACCUM;
                end
                ACCUM: begin
                    if (restart)       state_nxt = SETTLE;
                    else if (wd_fire)  state_nxt = IDLE;
                    else if (win_last) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy        = active;
        timeout_err = wd_fire;
    end

    // Partial counts are dropped whenever the conversion is abandoned or not running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt <= '0;
            tot_cnt    <= '0;
            src_cnt    <= '0;
        end else if (!enable || state == IDLE || restart || wd_fire) begin
            settle_cnt <= '0;
            tot_cnt    <= '0;
            src_cnt    <= '0;
        end else if (state == SETTLE) begin
            if (ev) settle_cnt <= settle_cnt + 1'b1;
            tot_cnt <= '0;
            src_cnt <= '0;
        end else if (ev) begin
            tot_cnt <= tot_cnt + 1'b1;
            src_cnt <= src_cnt + CW'(src_evt);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_data  <= '0;
            res_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (done) begin
            res_data  <= src_cnt + CW'(src_evt);
            res_valid <= 1'b1;
            if (res_valid && !res_ready) overrun <= 1'b1;
            else if (hs)                 overrun <= 1'b0;
        end else if (hs) begin
            res_valid <= 1'b0;
            overrun   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (both_evt) begin
            proto_err <= 1'b1;
        end else if (hs) begin
            proto_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tmp_result_decoder.sv
// Directed bench for tmp_result_decoder with an expected-result queue drained on each handshake.
module tb_tmp_result_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       conv_start = 1'b0;
    logic       src_evt = 1'b0;
    logic       snk_evt = 1'b0;
    logic       res_ready = 1'b0;
    logic [6:0] res_data;
    logic       res_valid, busy, overrun, proto_err, timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    tmp_result_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .conv_start  (conv_start),
        .src_evt     (src_evt),
        .snk_evt     (snk_evt),
        .res_data    (res_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .busy        (busy),
        .overrun     (overrun),
        .proto_err   (proto_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Each handshake retires the oldest expected result.
    always @(negedge clk) begin
        if (!reset && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL unexpected_result observed=%0d expected=none", res_data);
            end else begin
                chk("result_data", int'(res_data), exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit s, input bit k);
        src_evt = s;
        snk_evt = k;
        tick();
        src_evt = 1'b0;
        snk_evt = 1'b0;
    endtask

    task automatic start();
        conv_start = 1'b1;
        tick();
        conv_start = 1'b0;
    endtask

    task automatic settle(input bit s);
        for (int i = 0; i < 5; i++) send(s, !s);
    endtask

    // Full 64-event window: nsrc src events first, then snk events.
    task automatic window(input int nsrc);
        for (int i = 0; i < 64; i++) send(i < nsrc, i >= nsrc);
    endtask

    initial begin
        #2;
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_proto_err", int'(proto_err), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);
        tick();
        tick();
        reset = 1'b0;
        enable = 1'b1;
        res_ready = 1'b1;
        tick();

        // Alternating window: density 32, latency one cycle.
        start();
        chk("t1_busy_after_start", int'(busy), 1);
        settle(1'b0);
        for (int i = 0; i < 63; i++) send(i[0] == 1'b0, i[0] == 1'b1);
        chk("t1_valid_before_last", int'(res_valid), 0);
        exp_q.push_back(32);
        send(1'b0, 1'b1);
        chk("t1_valid", int'(res_valid), 1);
        chk("t1_data", int'(res_data), 32);
        chk("t1_busy_done", int'(busy), 0);
        tick();
        chk("t1_valid_drop", int'(res_valid), 0);

        // All-src then all-snk windows.
        start();
        settle(1'b1);
        exp_q.push_back(64);
        window(64);
        chk("t2_data_64", int'(res_data), 64);
        start();
        settle(1'b1);
        exp_q.push_back(0);
        window(0);
        chk("t2_data_0", int'(res_data), 0);
        chk("t2_no_overrun", int'(overrun), 0);
        tick();

        // Overwrite while unread.
        res_ready = 1'b0;
        start();
        settle(1'b0);
        window(48);
        chk("t3_first_data", int'(res_data), 48);
        chk("t3_first_overrun", int'(overrun), 0);
        start();
        settle(1'b0);
        window(16);
        chk("t3_data", int'(res_data), 16);
        chk("t3_overrun", int'(overrun), 1);
        chk("t3_valid", int'(res_valid), 1);
        exp_q.push_back(16);
        res_ready = 1'b1;
        tick();
        chk("t3_overrun_clear", int'(overrun), 0);
        chk("t3_valid_drop", int'(res_valid), 0);

        // Protocol error in ACCUM: not counted.
        start();
        settle(1'b0);
        for (int i = 0; i < 10; i++) send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        chk("t4_proto_err", int'(proto_err), 1);
        for (int i = 0; i < 53; i++) send(1'b0, 1'b1);
        chk("t4_valid_after_63", int'(res_valid), 0);
        exp_q.push_back(10);
        send(1'b0, 1'b1);
        chk("t4_valid", int'(res_valid), 1);
        chk("t4_data", int'(res_data), 10);
        tick();
        chk("t4_proto_clear", int'(proto_err), 0);

        // Watchdog with a held result.
        res_ready = 1'b0;
        start();
        settle(1'b0);
        window(7);
        start();
        settle(1'b1);
        for (int i = 0; i < 20; i++) send(1'b1, 1'b0);
        for (int i = 0; i < 254; i++) tick();
        chk("t5_no_early_timeout", int'(timeout_err), 0);
        chk("t5_busy_waiting", int'(busy), 1);
        tick();
        chk("t5_timeout_pulse", int'(timeout_err), 1);
        tick();
        chk("t5_timeout_end", int'(timeout_err), 0);
        chk("t5_busy_idle", int'(busy), 0);
        chk("t5_valid_held", int'(res_valid), 1);
        chk("t5_data_held", int'(res_data), 7);
        exp_q.push_back(7);
        res_ready = 1'b1;
        tick();

        // Restart mid-window.
        start();
        settle(1'b0);
        for (int i = 0; i < 30; i++) send(1'b1, 1'b0);
        start();
        chk("t6_busy_restart", int'(busy), 1);
        settle(1'b0);
        for (int i = 0; i < 63; i++) send(i < 40, i >= 40);
        chk("t6_valid_before_last", int'(res_valid), 0);
        exp_q.push_back(40);
        send(1'b0, 1'b1);
        chk("t6_data", int'(res_data), 40);
        tick();

        // enable low abandons the conversion.
        start();
        settle(1'b0);
        for (int i = 0; i < 10; i++) send(1'b1, 1'b0);
        enable = 1'b0;
        tick();
        chk("t8_busy_disabled", int'(busy), 0);
        enable = 1'b1;
        for (int i = 0; i < 60; i++) send(1'b1, 1'b0);
        chk("t8_no_result", int'(res_valid), 0);

        // Asynchronous reset mid-window.
        res_ready = 1'b0;
        start();
        settle(1'b0);
        window(5);
        start();
        settle(1'b0);
        send(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) send(1'b1, 1'b0);
        chk("t7_pre_valid", int'(res_valid), 1);
        chk("t7_pre_proto", int'(proto_err), 1);
        #1 reset = 1'b1;
        #1;
        chk("t7_res_data", int'(res_data), 0);
        chk("t7_res_valid", int'(res_valid), 0);
        chk("t7_busy", int'(busy), 0);
        chk("t7_overrun", int'(overrun), 0);
        chk("t7_proto_err", int'(proto_err), 0);
        chk("t7_timeout_err", int'(timeout_err), 0);
        tick();
        reset = 1'b0;
        tick();

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
